// File: rtl/regfile_port_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_port_sequencer_pkg
// Shared definitions for the register-file port sequencer: the sequencer
// state enumeration, the default register window, the rs/rt field positions
// inside the instruction word, and a helper that tests whether a register
// number falls inside the window held by the register file.
// -----------------------------------------------------------------------------
package regfile_port_sequencer_pkg;

    localparam int unsigned REG_BASE_DEFAULT  = 8;
    localparam int unsigned REG_COUNT_DEFAULT = 16;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // Operand register fields of the instruction word.
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_RS,
        READ_RT,
        DONE
    } state_e;

    // True when addr names a register physically present in the file.
    function automatic logic reg_in_range(input reg_addr_t addr,
                                          input int unsigned base,
                                          input int unsigned count);
        logic [31:0] addr_ext;
        addr_ext = {27'd0, addr};
        return (addr_ext >= base) && (addr_ext < base + count);
    endfunction

endpackage

// File: rtl/regfile_port_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_port_sequencer_if
// Bundles every non-clock signal of the sequencer.
//   start/instruction/ready       operand-read request handshake
//   wbValid/wbAddress/wbData/wbReady  writeback request handshake
//   regWrite/regAddress/dataIn/dataOut  single-port register file port
//   rsData/rtData/operandsValid   operand result, strobed for one cycle
//   addrError                     pulse on an out-of-range access
// The master modport is the surrounding pipeline plus register file; the
// slave modport is the sequencer itself.
// -----------------------------------------------------------------------------
interface regfile_port_sequencer_if;
    import regfile_port_sequencer_pkg::*;

    logic      start;
    logic [31:0] instruction;
    logic      ready;

    logic      wbValid;
    reg_addr_t wbAddress;
    reg_data_t wbData;
    logic      wbReady;

    logic      regWrite;
    reg_addr_t regAddress;
    reg_data_t dataIn;
    reg_data_t dataOut;

    reg_data_t rsData;
    reg_data_t rtData;
    logic      operandsValid;
    logic      addrError;

    modport master (
        output start, instruction, wbValid, wbAddress, wbData, dataOut,
        input  ready, wbReady, regWrite, regAddress, dataIn,
               rsData, rtData, operandsValid, addrError
    );

    modport slave (
        input  start, instruction, wbValid, wbAddress, wbData, dataOut,
        output ready, wbReady, regWrite, regAddress, dataIn,
               rsData, rtData, operandsValid, addrError
    );

endinterface

// File: rtl/regfile_port_sequencer_wb_hold_buffer.sv
// -----------------------------------------------------------------------------
// wb_hold_buffer
// One-entry holding register for a pending register-file write.
//   clk, reset_n         clock, asynchronous active-low reset
//   load                 capture load_addr/load_data and mark full
//   clear                drop the entry (used once the write is performed)
//   full, addr, data     current entry
// load takes priority over clear; the owner never asserts both in a cycle.
// -----------------------------------------------------------------------------
module wb_hold_buffer
    import regfile_port_sequencer_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load,
    input  reg_addr_t load_addr,
    input  reg_data_t load_data,
    input  logic      clear,
    output logic      full,
    output reg_addr_t addr,
    output reg_data_t data
);

    logic      full_q, full_d;
    reg_addr_t addr_q, addr_d;
    reg_data_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            addr_d = load_addr;
            data_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            // NOTE: the stored address/data are reset as well, so the forwarding
            // compare and the register-file port never see X after reset.
            addr_q <= '0;
            data_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // only, so every flop samples the values from before the edge.
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/regfile_port_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_port_sequencer
// Sequences operand reads and writebacks onto a single-port register file.
//   clk, reset_n   clock, asynchronous active-low reset
//   bus (slave)    request handshakes, register-file port and results
// A start accepted in IDLE reads rs, then rt, one per cycle, and presents
// both on rsData/rtData with operandsValid in the following DONE cycle, so
// ready is low for exactly three cycles. A writeback is parked in a one-entry
// buffer and performed from IDLE before any new read. Reads of a register
// held in the buffer return the buffered data. Register 0 reads as zero and
// swallows writes; other numbers outside the window read as zero, drop
// writes and raise addrError for one cycle after the offending access.
// -----------------------------------------------------------------------------
module regfile_port_sequencer
    import regfile_port_sequencer_pkg::*;
#(
    parameter int unsigned REG_BASE  = REG_BASE_DEFAULT,
    parameter int unsigned REG_COUNT = REG_COUNT_DEFAULT
) (
    input logic                    clk,
    input logic                    reset_n,
    regfile_port_sequencer_if.slave bus
);

    localparam reg_addr_t BASE_ADDR = reg_addr_t'(REG_BASE);

    state_e    state_q, state_d;
    reg_addr_t rs_q, rs_d, rt_q, rt_d;
    reg_data_t rs_tmp_q, rs_tmp_d;
    reg_data_t rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic      addr_error_q, addr_error_d;

    logic      buf_full, buf_clear, buf_load;
    reg_addr_t buf_addr;
    reg_data_t buf_data;

    logic      wb_accept, wb_in_range, wb_bad;
    logic      reading, read_valid, read_fwd, read_bad;
    reg_addr_t read_addr;
    reg_data_t read_value;
    logic      reg_write;
    reg_addr_t reg_address;
    reg_data_t data_in;
    logic      unused_instr_bits;

    assign unused_instr_bits = ^{bus.instruction[31:26], bus.instruction[15:0]};

    // Writeback side: an accepted write to an in-range register is parked;
    // register 0 is consumed silently, anything else out of range is flagged.
    assign wb_accept   = bus.wbValid && !buf_full;
    assign wb_in_range = reg_in_range(bus.wbAddress, REG_BASE, REG_COUNT);
    assign buf_load    = wb_accept && wb_in_range;
    assign wb_bad      = wb_accept && !wb_in_range && (bus.wbAddress != '0);

    wb_hold_buffer u_wb_hold_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (buf_load),
        .load_addr (bus.wbAddress),
        .load_data (bus.wbData),
        .clear     (buf_clear),
        .full      (buf_full),
        .addr      (buf_addr),
        .data      (buf_data)
    );

    // Read side: the buffer only ever holds in-range addresses, so an address
    // match already implies a valid register and wins over the file's data.
    assign reading    = (state_q == READ_RS) || (state_q == READ_RT);
    assign read_addr  = (state_q == READ_RT) ? rt_q : rs_q;
    assign read_valid = reg_in_range(read_addr, REG_BASE, REG_COUNT);
    assign read_fwd   = buf_full && (buf_addr == read_addr);
    assign read_bad   = reading && !read_valid && (read_addr != '0);
    assign read_value = !read_valid ? '0 : (read_fwd ? buf_data : bus.dataOut);

    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rs_tmp_d    = rs_tmp_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        reg_write   = 1'b0;
        reg_address = BASE_ADDR;
        data_in     = '0;
        buf_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (buf_full) begin
                    state_d = WRITE;
                end else if (bus.start) begin
                    state_d = READ_RS;
                    rs_d    = bus.instruction[RS_MSB:RS_LSB];
                    rt_d    = bus.instruction[RT_MSB:RT_LSB];
                end
            end
            WRITE: begin
                reg_write   = 1'b1;
                reg_address = buf_addr;
                data_in     = buf_data;
                buf_clear   = 1'b1;
                state_d     = IDLE;
            end
            READ_RS: begin
                if (read_valid) reg_address = read_addr;
                // rs is parked so rsData only changes together with rtData.
                rs_tmp_d = read_value;
                state_d  = READ_RT;
            end
            READ_RT: begin
                if (read_valid) reg_address = read_addr;
                rs_data_d = rs_tmp_q;
                rt_data_d = read_value;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        addr_error_d = read_bad || wb_bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rs_q         <= '0;
            rt_q         <= '0;
            rs_tmp_q     <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rs_tmp_q     <= rs_tmp_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign bus.ready         = (state_q == IDLE) && !buf_full;
    assign bus.wbReady       = !buf_full;
    assign bus.regWrite      = reg_write;
    assign bus.regAddress    = reg_address;
    assign bus.dataIn        = data_in;
    assign bus.rsData        = rs_data_q;
    assign bus.rtData        = rt_data_q;
    assign bus.operandsValid = (state_q == DONE);
    assign bus.addrError     = addr_error_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_sequencer
// Drives directed operand reads and writebacks into regfile_port_sequencer,
// hosts the register file it talks to, and compares every result and every
// register-file write against an architectural model of the register window.
// -----------------------------------------------------------------------------
module tb_regfile_port_sequencer;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
    } rd_exp_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    regfile_port_sequencer_if bus();

    regfile_port_sequencer #(.REG_BASE(8), .REG_COUNT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register file behind the port, with a few known preloads.
    logic [31:0] rf [0:31] = '{8: 32'h11, 9: 32'h0909, 10: 32'h1234,
                               13: 32'h1313_1313, 23: 32'h22, default: 32'h0};
    assign bus.dataOut = rf[bus.regAddress];
    always @(posedge clk) if (bus.regWrite) rf[bus.regAddress] <= bus.dataIn;

    // Architectural model: the value each register number must read as.
    logic [31:0] arch [0:31] = '{8: 32'h11, 9: 32'h0909, 10: 32'h1234,
                                 13: 32'h1313_1313, 23: 32'h22, default: 32'h0};
    rd_exp_t     rq [$];
    wr_exp_t     wq [$];
    int          err_exp  = 0;
    int          err_seen = 0;
    logic [31:0] last_rs  = 32'h0;
    logic [31:0] last_rt  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic in_window(input logic [4:0] r);
        return (r >= 5'd8) && (r <= 5'd23);
    endfunction

    function automatic logic [31:0] model_val(input logic [4:0] r);
        return in_window(r) ? arch[r] : 32'h0;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (in_window(a)) begin
            arch[a] = d;
            wq.push_back('{addr: a, data: d});
        end else if (a != 5'd0) begin
            err_exp++;
        end
    endtask

    task automatic model_read(input logic [4:0] rs, input logic [4:0] rt);
        rq.push_back('{rs: model_val(rs), rt: model_val(rt)});
        if (!in_window(rs) && rs != 5'd0) err_exp++;
        if (!in_window(rt) && rt != 5'd0) err_exp++;
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin : compare
        rd_exp_t r;
        wr_exp_t w;
        if (!reset_n) begin
            rq.delete();
            wq.delete();
            last_rs = 32'h0;
            last_rt = 32'h0;
        end else begin
            if (bus.regWrite) begin
                check("regwrite_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("regwrite_addr", 32'(bus.regAddress), 32'(w.addr));
                    check("regwrite_data", bus.dataIn, w.data);
                end
            end else begin
                check("datain_idle", bus.dataIn, 32'h0);
            end
            if (bus.operandsValid) begin
                check("operands_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    last_rs = r.rs;
                    last_rt = r.rt;
                end
            end
            check("rs_data", bus.rsData, last_rs);
            check("rt_data", bus.rtData, last_rt);
            if (bus.addrError) err_seen++;
        end
    end

    // Presents a read and/or a write in one cycle once the DUT can take them.
    task automatic issue(input logic do_start, input logic [4:0] rs, input logic [4:0] rt,
                         input logic do_wb, input logic [4:0] wa, input logic [31:0] wd);
        int budget = 0;
        while (!((!do_start || bus.ready) && (!do_wb || bus.wbReady)) && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("issue_ready_timeout", 32'(budget < 20), 32'd1);
        bus.start       = do_start;
        bus.instruction = {6'h3F, rs, rt, 16'hBEEF};
        bus.wbValid     = do_wb;
        bus.wbAddress   = wa;
        bus.wbData      = wd;
        if (do_wb) model_write(wa, wd);
        if (do_start) model_read(rs, rt);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.wbValid = 1'b0;
    endtask

    task automatic wait_valid(output int writes_before);
        logic ok = 1'b0;
        writes_before = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = bus.operandsValid;
            if (bus.regWrite) writes_before++;
        end
        check("operands_valid_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_write();
        logic ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            ok = bus.regWrite;
        end
        check("regwrite_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr;
        int e0;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.instruction = 32'h0;
        bus.wbValid     = 1'b0;
        bus.wbAddress   = 5'd0;
        bus.wbData      = 32'h0;

        // Reset values.
        #2;
        check("rst_regwrite", 32'(bus.regWrite), 32'd0);
        check("rst_regaddress", 32'(bus.regAddress), 32'd8);
        check("rst_datain", bus.dataIn, 32'h0);
        check("rst_rsdata", bus.rsData, 32'h0);
        check("rst_rtdata", bus.rtData, 32'h0);
        check("rst_valid", 32'(bus.operandsValid), 32'd0);
        check("rst_addrerror", 32'(bus.addrError), 32'd0);
        #10;
        reset_n = 1'b1;
        #1;
        check("release_ready", 32'(bus.ready), 32'd1);
        check("release_wbready", 32'(bus.wbReady), 32'd1);
        @(posedge clk); #1;

        // Write DEADBEEF to reg 9, then read rs=9, rt=0.
        issue(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        check("buffered_wbready", 32'(bus.wbReady), 32'd0);
        check("buffered_ready", 32'(bus.ready), 32'd0);
        wait_write();
        check("write_pulse_addr", 32'(bus.regAddress), 32'd9);
        check("write_pulse_data", bus.dataIn, 32'hDEAD_BEEF);
        issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0);
        wait_valid(wr);
        check("r031_rs", bus.rsData, 32'hDEAD_BEEF);
        check("r031_rt", bus.rtData, 32'h0);

        // rs=8, rt=23: address sequence and three cycles of ready low.
        issue(1'b1, 5'd8, 5'd23, 1'b0, 5'd0, 32'h0);
        check("r032_rs_ready", 32'(bus.ready), 32'd0);
        check("r032_rs_addr", 32'(bus.regAddress), 32'd8);
        @(posedge clk); #1;
        check("r032_rt_ready", 32'(bus.ready), 32'd0);
        check("r032_rt_addr", 32'(bus.regAddress), 32'd23);
        @(posedge clk); #1;
        check("r032_done_ready", 32'(bus.ready), 32'd0);
        check("r032_done_valid", 32'(bus.operandsValid), 32'd1);
        check("r032_rs", bus.rsData, 32'h11);
        check("r032_rt", bus.rtData, 32'h22);
        @(posedge clk); #1;
        check("r032_idle_ready", 32'(bus.ready), 32'd1);
        check("r032_idle_valid", 32'(bus.operandsValid), 32'd0);

        // Same-cycle start and writeback to reg 10: forwarded, written after DONE.
        issue(1'b1, 5'd10, 5'd0, 1'b1, 5'd10, 32'h5A5A);
        wait_valid(wr);
        check("r033_rs_forwarded", bus.rsData, 32'h5A5A);
        check("r033_no_early_write", 32'(wr), 32'd0);
        wait_write();
        check("r033_write_addr", 32'(bus.regAddress), 32'd10);
        @(posedge clk); #1;
        check("r033_rf10", rf[10], 32'h5A5A);

        // Out-of-range read and write.
        e0 = err_seen;
        issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
        wait_valid(wr);
        check("r034_rs_zero", bus.rsData, 32'h0);
        check("r034_read_err_pulses", 32'(err_seen - e0), 32'd1);
        e0 = err_seen;
        issue(1'b0, 5'd0, 5'd0, 1'b1, 5'd30, 32'h3030);
        wr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.regWrite) wr++;
        end
        check("r034_no_regwrite", 32'(wr), 32'd0);
        check("r034_write_err_pulses", 32'(err_seen - e0), 32'd1);

        // Further directed vectors, checked by the compare process.
        issue(1'b1, 5'd23, 5'd8,  1'b0, 5'd0,  32'h0);
        issue(1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFF_0000);
        issue(1'b1, 5'd0,  5'd24, 1'b0, 5'd0,  32'h0);
        issue(1'b1, 5'd12, 5'd12, 1'b1, 5'd12, 32'hABCD);
        issue(1'b0, 5'd0,  5'd0,  1'b1, 5'd15, 32'h1515);
        issue(1'b1, 5'd15, 5'd7,  1'b0, 5'd0,  32'h0);
        issue(1'b1, 5'd31, 5'd1,  1'b0, 5'd0,  32'h0);
        wait_valid(wr);
        check("vec_last_rs", bus.rsData, 32'h0);

        // Reset during READ_RT with the buffer full.
        issue(1'b1, 5'd8, 5'd23, 1'b1, 5'd13, 32'hC0DE);
        @(posedge clk); #1;
        check("r035_buffer_full", 32'(bus.wbReady), 32'd0);
        check("r035_rt_addr", 32'(bus.regAddress), 32'd23);
        reset_n = 1'b0;
        #1;
        arch[13] = 32'h1313_1313;
        check("r035_regwrite", 32'(bus.regWrite), 32'd0);
        check("r035_regaddress", 32'(bus.regAddress), 32'd8);
        check("r035_datain", bus.dataIn, 32'h0);
        check("r035_rsdata", bus.rsData, 32'h0);
        check("r035_rtdata", bus.rtData, 32'h0);
        check("r035_valid", 32'(bus.operandsValid), 32'd0);
        check("r035_addrerror", 32'(bus.addrError), 32'd0);
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        #1;
        check("r035_release_ready", 32'(bus.ready), 32'd1);
        check("r035_release_wbready", 32'(bus.wbReady), 32'd1);
        wr = 0;
        e0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.regWrite) wr++;
            if (bus.operandsValid) e0++;
        end
        check("r035_no_regwrite", 32'(wr), 32'd0);
        check("r035_no_valid", 32'(e0), 32'd0);
        check("r035_rf13_kept", rf[13], 32'h1313_1313);

        // Normal operation after the mid-sequence reset.
        issue(1'b1, 5'd13, 5'd8, 1'b0, 5'd0, 32'h0);
        wait_valid(wr);
        check("post_rst_rs", bus.rsData, 32'h1313_1313);
        check("post_rst_rt", bus.rtData, 32'h11);

        repeat (10) @(posedge clk);
        #1;
        check("addr_error_total", 32'(err_seen), 32'(err_exp));
        check("reads_outstanding", 32'(rq.size()), 32'd0);
        check("writes_outstanding", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
